// File: rtl/fb_pixel_writer_pkg.sv
// Shared definitions for the framebuffer write port: geometry, bus widths, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fb_pixel_writer_pkg;

  localparam int PIXEL_SIZE = 8;    // RRRGGGBB
  localparam int FB_WIDTH   = 640;  // default visible pixels per line
  localparam int FB_HEIGHT  = 480;  // default visible lines per frame
  localparam int ADR_BITS   = 26;   // word address, MemAdr[26:1]
  localparam int COORD_BITS = 11;   // x / y coordinate width

  // Write-side bus FSM encodings
  typedef enum logic [1:0] {
    FBW_IDLE  = 2'd0,
    FBW_SETUP = 2'd1,
    FBW_WRITE = 2'd2,
    FBW_HOLD  = 2'd3
  } fbwState_t;

  // A pixel occupies the low byte of a RAM word; the upper byte lane is never enabled.
  function automatic logic [15:0] pixelWord(input logic [PIXEL_SIZE-1:0] colour);
    return {8'h00, colour};
  endfunction

endpackage

// File: rtl/fb_addr_calc.sv
// Linear framebuffer address y*WIDTH+x, registered on load, with a combinational range check.
// Latency: 1 clock from load to adr; inRange is same-cycle.
// Backpressure: none; caller decides when to load.
// Ports: clk, resetn (sync, active low), load, x, y -> inRange (comb), adr (registered).
module fb_addr_calc
  import fb_pixel_writer_pkg::*;
#(
  parameter int WIDTH  = FB_WIDTH,
  parameter int HEIGHT = FB_HEIGHT
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  load,
  input  logic [COORD_BITS-1:0] x,
  input  logic [COORD_BITS-1:0] y,
  output logic                  inRange,
  output logic [ADR_BITS-1:0]   adr
);

  localparam logic [COORD_BITS:0] WIDTH_L  = (COORD_BITS+1)'(WIDTH);
  localparam logic [COORD_BITS:0] HEIGHT_L = (COORD_BITS+1)'(HEIGHT);
  localparam logic [ADR_BITS-1:0] WIDTH_A  = ADR_BITS'(WIDTH);

  // Extra top bit so a WIDTH/HEIGHT equal to 2**COORD_BITS still compares correctly.
  assign inRange = ({1'b0, x} < WIDTH_L) && ({1'b0, y} < HEIGHT_L);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      adr <= '0;
    end else if (load) begin
      adr <= {{(ADR_BITS-COORD_BITS){1'b0}}, y} * WIDTH_A
           + {{(ADR_BITS-COORD_BITS){1'b0}}, x};
    end
  end

endmodule

// File: rtl/fb_pixel_writer.sv
// Framebuffer write port: single pixel writes or whole-frame fill as async cellular-RAM write cycles.
// Latency: accept at edge N -> SETUP N+1, MemWR low N+2..N+1+WE_CYCLES, HOLD, ready again N+3+WE_CYCLES.
// Backpressure: pix_ready low while a cycle or fill is active, or while the display is not blanking.
// Ports: clk, resetn (sync, active low), blank, pix_valid/pix_ready/pix_x/pix_y/pix_data,
//        fill_start/fill_color, busy, oob (sticky), RAM bus: mem_adr, mem_dq_out, mem_dq_oe,
//        mem_wr_n, mem_oe_n, ram_cs_n, ram_lb_n, ram_ub_n. MemDB tri-state lives in the chip top.
module fb_pixel_writer
  import fb_pixel_writer_pkg::*;
#(
  parameter int WIDTH     = FB_WIDTH,
  parameter int HEIGHT    = FB_HEIGHT,
  parameter int WE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  blank,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  input  logic [COORD_BITS-1:0] pix_x,
  input  logic [COORD_BITS-1:0] pix_y,
  input  logic [PIXEL_SIZE-1:0] pix_data,
  input  logic                  fill_start,
  input  logic [PIXEL_SIZE-1:0] fill_color,
  output logic                  busy,
  output logic                  oob,
  output logic [ADR_BITS-1:0]   mem_adr,
  output logic [15:0]           mem_dq_out,
  output logic                  mem_dq_oe,
  output logic                  mem_wr_n,
  output logic                  mem_oe_n,
  output logic                  ram_cs_n,
  output logic                  ram_lb_n,
  output logic                  ram_ub_n
);

  localparam int                  FB_WORDS = WIDTH * HEIGHT;
  localparam logic [ADR_BITS-1:0] LAST_ADR = ADR_BITS'(FB_WORDS - 1);
  localparam int                  WCW      = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;
  localparam logic [WCW-1:0]      WE_LAST  = WCW'(WE_CYCLES - 1);

  fbwState_t             state;
  logic                  fillActive;
  logic                  fillMode;    // current/last bus cycle came from the fill engine
  logic [PIXEL_SIZE-1:0] fillColour;
  logic [ADR_BITS-1:0]   fillCnt;
  logic [ADR_BITS-1:0]   fillAdr;
  logic [ADR_BITS-1:0]   calcAdr;
  logic                  inRange;
  logic [WCW-1:0]        weCnt;
  logic                  pixAccept;
  logic                  fillStartOk;

  assign pix_ready   = (state == FBW_IDLE) && blank && !fillActive;
  assign fillStartOk = fill_start && (state == FBW_IDLE) && !fillActive;
  // A fill request in the same cycle takes priority over a pending pixel.
  assign pixAccept   = pix_valid && pix_ready && !fill_start;
  assign busy        = fillActive || (state != FBW_IDLE);

  // Both address sources are registers, so the mux keeps mem_adr stable and held in IDLE.
  assign mem_adr  = fillMode ? fillAdr : calcAdr;
  assign mem_oe_n = 1'b1;
  assign ram_ub_n = 1'b1;

  fb_addr_calc #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_addrCalc (
    .clk     (clk),
    .resetn  (resetn),
    .load    (pixAccept && inRange),
    .x       (pix_x),
    .y       (pix_y),
    .inRange (inRange),
    .adr     (calcAdr)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= FBW_IDLE;
      fillActive <= 1'b0;
      fillMode   <= 1'b0;
      fillColour <= '0;
      fillCnt    <= '0;
      fillAdr    <= '0;
      weCnt      <= '0;
      oob        <= 1'b0;
      mem_dq_out <= '0;
      mem_dq_oe  <= 1'b0;
      mem_wr_n   <= 1'b1;
      ram_cs_n   <= 1'b1;
      ram_lb_n   <= 1'b1;
    end else begin
      case (state)
        FBW_IDLE: begin
          if (fillStartOk) begin
            fillActive <= 1'b1;
            fillCnt    <= '0;
            fillColour <= fill_color;
          end else if (fillActive && blank) begin
            fillMode   <= 1'b1;
            fillAdr    <= fillCnt;
            mem_dq_out <= pixelWord(fillColour);
            state      <= FBW_SETUP;
            ram_cs_n   <= 1'b0;
            ram_lb_n   <= 1'b0;
            mem_dq_oe  <= 1'b1;
          end else if (pixAccept) begin
            if (inRange) begin
              fillMode   <= 1'b0;
              mem_dq_out <= pixelWord(pix_data);
              state      <= FBW_SETUP;
              ram_cs_n   <= 1'b0;
              ram_lb_n   <= 1'b0;
              mem_dq_oe  <= 1'b1;
            end else begin
              oob <= 1'b1;  // request is consumed but never reaches the bus
            end
          end
        end
        FBW_SETUP: begin
          state    <= FBW_WRITE;
          mem_wr_n <= 1'b0;
          weCnt    <= '0;
        end
        FBW_WRITE: begin
          if (weCnt == WE_LAST) begin
            state    <= FBW_HOLD;
            mem_wr_n <= 1'b1;
          end else begin
            weCnt <= weCnt + 1'b1;
          end
        end
        FBW_HOLD: begin
          state     <= FBW_IDLE;
          ram_cs_n  <= 1'b1;
          ram_lb_n  <= 1'b1;
          mem_dq_oe <= 1'b0;
          if (fillMode && fillActive) begin
            if (fillCnt == LAST_ADR) fillActive <= 1'b0;
            else                     fillCnt    <= fillCnt + 1'b1;
          end
        end
        default: state <= FBW_IDLE;
      endcase
    end
  end

endmodule
